// File: rtl/pipes_pkg.sv
// Shared pipeline types for the data-memory controller: access sizes, FSM states
// and the registered bus request.
package pipes_pkg;

    typedef enum logic [1:0] {
        MSIZE_B = 2'b00,
        MSIZE_H = 2'b01,
        MSIZE_W = 2'b10
    } msize_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        DONE  = 2'b10,
        DRAIN = 2'b11
    } dmem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    // The unused 2'b11 encoding is treated as a word access.
    function automatic msize_t to_msize(input logic [1:0] s);
        case (s)
            2'b00:   return MSIZE_B;
            2'b01:   return MSIZE_H;
            default: return MSIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_load_ext.sv
// Load lane selection and sign/zero extension of a raw 32-bit bus word.
module load_ext
    import pipes_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  off,
    input  msize_t      size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        result = raw;
        case (size)
            MSIZE_B: result = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            MSIZE_H: result = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage controller: one outstanding bus transaction with flush drain.
// Optional alignment trap enabled by `define DMEM_CTRL_MISALIGN_CHK_EN.
module dmem_ctrl
    import pipes_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_mem_read,
    input  logic        m_mem_write,
    input  logic [1:0]  m_size,
    input  logic        m_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flushM,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        stallM,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign
);

    dmem_state_t state, state_nx;
    dbus_req_t   req_q, req_d;
    msize_t      size_in, size_q;
    logic        uns_q, rd_q;
    logic [31:0] resp_q, ext_data;
    logic        mem_op, mis_cond, start, lv;

    assign size_in = to_msize(m_size);
    assign mem_op  = m_valid & (m_mem_read | m_mem_write);

`ifdef DMEM_CTRL_MISALIGN_CHK_EN
    assign mis_cond = ((size_in == MSIZE_H) && addr[0]) ||
                      ((size_in == MSIZE_W) && (addr[1:0] != 2'b00));
`else
    assign mis_cond = 1'b0;
`endif

    // Write wins when both read and write are asserted; reads carry no strobe/data.
    always_comb begin
        req_d.addr   = addr;
        req_d.strobe = '0;
        req_d.data   = '0;
        case (size_in)
            MSIZE_B: begin
                if (m_mem_write) begin
                    req_d.strobe = 4'b0001 << addr[1:0];
                    req_d.data   = {4{wdata[7:0]}};
                end
            end
            MSIZE_H: begin
                req_d.addr[0] = 1'b0;
                if (m_mem_write) begin
                    req_d.strobe = addr[1] ? 4'b1100 : 4'b0011;
                    req_d.data   = {2{wdata[15:0]}};
                end
            end
            default: begin
                req_d.addr[1:0] = 2'b00;
                if (m_mem_write) begin
                    req_d.strobe = 4'b1111;
                    req_d.data   = wdata;
                end
            end
        endcase
    end

    always_comb begin
        state_nx   = state;
        stallM     = 1'b0;
        dreq_valid = 1'b0;
        lv         = 1'b0;
        misalign   = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !flushM) begin
                    if (mis_cond) begin
                        misalign = 1'b1;
                    end else begin
                        start    = 1'b1;
                        stallM   = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                dreq_valid = 1'b1;
                if (flushM) begin
                    state_nx = dresp_data_ok ? IDLE : DRAIN;
                end else begin
                    stallM = 1'b1;
                    if (dresp_data_ok) state_nx = DONE;
                end
            end
            DONE: begin
                lv       = rd_q;
                state_nx = IDLE;
            end
            DRAIN: begin
                dreq_valid = 1'b1;
                stallM     = mem_op && !flushM;
                if (dresp_data_ok) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset silences every output in the same cycle, abandoning any transaction.
        if (reset) begin
            stallM     = 1'b0;
            dreq_valid = 1'b0;
            lv         = 1'b0;
            misalign   = 1'b0;
            start      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            req_q  <= '0;
            size_q <= MSIZE_B;
            uns_q  <= 1'b0;
            rd_q   <= 1'b0;
            resp_q <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                req_q  <= req_d;
                size_q <= size_in;
                uns_q  <= m_unsigned;
                rd_q   <= ~m_mem_write;
            end
            if (state == REQ && dresp_data_ok && !flushM) resp_q <= dresp_data;
        end
    end

    load_ext u_load_ext (
        .raw    (resp_q),
        .off    (req_q.addr[1:0]),
        .size   (size_q),
        .uns    (uns_q),
        .result (ext_data)
    );

    assign dreq_addr   = dreq_valid ? req_q.addr   : '0;
    assign dreq_strobe = dreq_valid ? req_q.strobe : '0;
    assign dreq_data   = dreq_valid ? req_q.data   : '0;
    assign load_valid  = lv;
    assign load_data   = lv ? ext_data : '0;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-002 SHALL have these inputs from the memory stage: m_valid (1, instruction present in M), m_mem_read (1), m_mem_write (1), m_size (2; 00 byte, 01 half, 10 word), m_unsigned (1, zero-extend load), addr (32, ALU result), wdata (32, store data), flushM (1).
REQ-003 SHALL have these bus request outputs: dreq_valid (1), dreq_addr (32), dreq_strobe (4, byte write enables, 0000 for reads), dreq_data (32).
REQ-004 SHALL have these bus response inputs: dresp_data_ok (1, one-cycle pulse), dresp_data (32).
REQ-005 SHALL have these pipeline outputs: stallM (1), load_data (32, extended load result), load_valid (1), misalign (1).

Function
REQ-006 SHALL treat a memory op as m_valid & (m_mem_read | m_mem_write); both read and write asserted together is illegal, and write SHALL win.
REQ-007 SHALL implement the FSM IDLE, REQ, DONE, DRAIN (dmem_state_t).
REQ-008 IDLE: a legal memory op without flushM SHALL go to REQ, assert stallM=1, and hold dreq_valid=0 this cycle.
REQ-009 REQ: dreq_valid=1 and stallM=1; request fields SHALL be registered copies captured on leaving IDLE; on dresp_data_ok SHALL go to DONE and register dresp_data.
REQ-010 DONE: stallM=0; load_valid=1 for reads; load_data SHALL be the extended registered response; next state SHALL be IDLE unconditionally.
REQ-011 Minimum latency SHALL be 3 cycles (op seen, request with data_ok, result), and each extra bus wait cycle SHALL add one cycle.
REQ-012 Store strobes: sb SHALL drive 1<<addr[1:0] with the byte replicated on all lanes; sh SHALL drive 0011 (addr[1]=0) or 1100 with the half replicated; sw SHALL drive 1111.
REQ-013 Loads SHALL select the byte/half lane by addr[1:0] and sign-extend unless m_unsigned.
REQ-014 Non-memory or invalid instruction SHALL give stallM=0, load_valid=0, and no bus activity.
REQ-015 flushM in IDLE SHALL suppress the request; flushM in REQ SHALL go to DRAIN (request kept to completion, stallM=0); DRAIN SHALL discard the response and return to IDLE on dresp_data_ok; load_valid SHALL never be asserted for a flushed op.
REQ-016 A new op arriving while in DRAIN SHALL stall (stallM=1) until DRAIN exits.
REQ-017 dreq_valid SHALL never deassert before dresp_data_ok, and request fields SHALL stay stable while dreq_valid=1.

Reset
REQ-018 On reset the state SHALL be IDLE and all outputs SHALL be 0 (stallM, dreq_valid, dreq_strobe, load_valid, misalign, load_data, dreq_addr, dreq_data).
REQ-019 Reset mid-REQ SHALL abandon the transaction immediately, and a late dresp_data_ok SHALL be ignored in IDLE.

Configuration
REQ-020 With DMEM_CTRL_MISALIGN_CHK_EN defined, a half op with addr[0]=1 or a word op with addr[1:0]!=0 SHALL assert misalign=1 combinationally, issue no request, leave stallM=0, and stay in IDLE.
REQ-021 Without DMEM_CTRL_MISALIGN_CHK_EN, misalign SHALL be tied 0 and the address low bits SHALL be forced to alignment (half: bit0=0; word: bits1:0=0).

Structure
REQ-022 msize_t (MSIZE_B/H/W) and dmem_state_t SHALL live in the shared pipes package, together with a dbus request struct for the registered request fields.
REQ-023 Load extraction SHALL be a combinational sub-module load_ext (inputs: raw data, addr[1:0], size, unsigned; output: 32-bit result).

Verification
REQ-024 lw at 0x100 with bus data 0xDEADBEEF and data_ok in the first REQ cycle -> stallM 1,1,0; load_data=0xDEADBEEF; load_valid for one cycle.
REQ-025 lb at 0x103 with data 0x80112233, signed -> 0xFFFFFF80; lbu -> 0x00000080.
REQ-026 sh at 0x202 with wdata 0x0000ABCD -> dreq_strobe=1100, dreq_data=0xABCDABCD, and a 3-cycle bus delay held stable with stallM=1 throughout.
REQ-027 flushM in REQ with data_ok 2 cycles later -> stallM=0, DRAIN for 2 cycles, load_valid never 1; a following lw stalls until IDLE.
REQ-028 With the macro defined, lw at 0x102 -> misalign=1, dreq_valid=0, stallM=0; without the macro the same access -> dreq_addr=0x100.
REQ-029 Reset asserted in REQ with a data_ok pulse in the next cycle -> IDLE, all outputs 0, no load_valid.
